// File: rtl/regex_instr_mem_arbiter_if.sv
// Fetch-side and BRAM-side bus of the shared instruction memory arbiter.
// The arbiter uses the slave view; the CPU array plus BRAM model use the master view.
interface regex_instr_mem_arbiter_if #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int ID_BITS           = (N_CPU > 1) ? $clog2(N_CPU) : 1
);
  logic [N_CPU-1:0]                   cpu_mem_valid;
  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_mem_addr;
  logic [N_CPU-1:0]                   cpu_mem_ready;
  logic [MEMORY_WIDTH-1:0]            cpu_mem_data;
  logic                               mem_en;
  logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr;
  logic [MEMORY_WIDTH-1:0]            mem_rdata;
  logic                               busy;
  logic [ID_BITS-1:0]                 grant_id;

  modport slave (
    input  cpu_mem_valid, cpu_mem_addr, mem_rdata,
    output cpu_mem_ready, cpu_mem_data, mem_en, mem_addr, busy, grant_id
  );

  modport master (
    output cpu_mem_valid, cpu_mem_addr, mem_rdata,
    input  cpu_mem_ready, cpu_mem_data, mem_en, mem_addr, busy, grant_id
  );
endinterface

// File: rtl/regex_instr_mem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction BRAM between N_CPU
// fetch ports, one outstanding read at a time. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for any fetch request; arbitration happens here
// READ  | BRAM read in flight; mem_en pulses in the first cycle only
// ACK   | ready pulse to the winner is visible; capture BRAM data
module regex_instr_mem_arbiter #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEM_LATENCY       = 1
) (
  input logic                     clk_i,
  input logic                     rst_i,
  regex_instr_mem_arbiter_if.slave bus
);
  localparam int ID_BITS  = (N_CPU > 1) ? $clog2(N_CPU) : 1;
  localparam int LAT_BITS = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [ID_BITS-1:0]           rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]           grant_id_q, grant_id_d;
  logic [LAT_BITS-1:0]          lat_cnt_q, lat_cnt_d;
  logic [N_CPU-1:0]             ready_q, ready_d;
  logic [MEMORY_WIDTH-1:0]      data_q, data_d;
  logic                         mem_en_q, mem_en_d;
  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                         busy_q, busy_d;

  logic [MEMORY_ADDR_WIDTH-1:0] addr_arr [N_CPU];
  logic [ID_BITS:0]             idx_w;
  logic [ID_BITS-1:0]           winner;
  logic                         found;

  // Split the flat address bus into per-CPU addresses
  always_comb begin
    for (int i = 0; i < N_CPU; i++) begin
      addr_arr[i] = bus.cpu_mem_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping mod N_CPU
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx_w  = '0;
    for (int k = 0; k < N_CPU; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (ID_BITS+1)'(k);
      if (idx_w >= (ID_BITS+1)'(N_CPU)) begin
        idx_w = idx_w - (ID_BITS+1)'(N_CPU);
      end
      if (!found && bus.cpu_mem_valid[idx_w[ID_BITS-1:0]]) begin
        found  = 1'b1;
        winner = idx_w[ID_BITS-1:0];
      end
    end
  end

  // Next-state logic for the transaction FSM and its output registers
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    lat_cnt_d  = lat_cnt_q;
    ready_d    = '0;
    data_d     = data_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_id_d = winner;
          mem_addr_d = addr_arr[winner];
          mem_en_d   = 1'b1;
          lat_cnt_d  = LAT_BITS'(MEM_LATENCY - 1);
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (lat_cnt_q == '0) begin
          for (int i = 0; i < N_CPU; i++) begin
            if (ID_BITS'(i) == grant_id_q) ready_d[i] = 1'b1;
          end
          state_d = ST_ACK;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        data_d   = bus.mem_rdata;
        rr_ptr_d = (grant_id_q == ID_BITS'(N_CPU - 1)) ? '0 : grant_id_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Register state and outputs; synchronous reset discards any pending read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      lat_cnt_q  <= '0;
      ready_q    <= '0;
      data_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      lat_cnt_q  <= lat_cnt_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cpu_mem_ready = ready_q;
  assign bus.cpu_mem_data  = data_q;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = grant_id_q;
endmodule

// File: tb/tb_regex_instr_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants and timing from
// the arbitration rules; a separate monitor compares what the DUT presents.
module tb_regex_instr_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int L  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regex_instr_mem_arbiter_if #(.N_CPU(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)) bus ();

  regex_instr_mem_arbiter #(
    .N_CPU(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(L)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // BRAM model: fixed latency L, junk on the data bus when no read returns
  logic [DW-1:0] tbl [0:(1<<AW)-1];
  logic [DW-1:0] pipe [L];
  always @(posedge clk) begin
    for (int s = L-1; s > 0; s--) pipe[s] <= pipe[s-1];
    pipe[0] <= bus.mem_en ? tbl[bus.mem_addr] : DW'($urandom);
  end
  assign bus.mem_rdata = pipe[L-1];

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            en_cyc;
    int            rdy_cyc;
  } txn_t;
  txn_t en_q[$];
  txn_t rdy_q[$];

  // Reference model: arbitration moments and expected response timing
  int   rr_m = 0;
  int   next_arb = 0;
  int   busy_lo = -100;
  int   busy_hi = -100;
  txn_t mt;
  always @(negedge clk) begin
    if (rst) begin
      en_q.delete();
      rdy_q.delete();
      rr_m = 0;
      next_arb = cyc + 1;
      busy_lo = -100;
      busy_hi = -100;
    end else if (cyc >= next_arb && bus.cpu_mem_valid != '0) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.cpu_mem_valid[(rr_m + k) % N]) w = (rr_m + k) % N;
      mt.id      = w;
      mt.addr    = bus.cpu_mem_addr[w*AW +: AW];
      mt.data    = tbl[mt.addr];
      mt.en_cyc  = cyc + 1;
      mt.rdy_cyc = cyc + 1 + L;
      en_q.push_back(mt);
      rdy_q.push_back(mt);
      rr_m     = (w + 1) % N;
      next_arb = cyc + L + 2;
      busy_lo  = cyc + 1;
      busy_hi  = cyc + 1 + L;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard each cycle
  bit            prev_rst = 1'b1;
  bit            prev_en = 1'b0;
  int            data_due = -1;
  logic [DW-1:0] data_exp = '0;
  logic [DW-1:0] held = '0;
  int            ack_cnt [N];
  int            got_ids[$];
  txn_t          ot;
  always @(posedge clk) begin
    #2;
    if (prev_rst) begin
      chk("rst_ready", 32'(bus.cpu_mem_ready), 0);
      chk("rst_data", 32'(bus.cpu_mem_data), 0);
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_grant", 32'(bus.grant_id), 0);
      held = '0;
      data_due = -1;
    end else begin
      chk("ready_onehot", 32'($countones(bus.cpu_mem_ready) <= 1), 1);
      if (bus.mem_en) begin
        chk("en_back2back", 32'(prev_en), 0);
        if (en_q.size() == 0) chk("unexpected_en", 1, 0);
        else begin
          ot = en_q.pop_front();
          chk("en_cycle", ot.en_cyc, cyc);
          chk("mem_addr", 32'(bus.mem_addr), 32'(ot.addr));
          chk("en_grant_id", 32'(bus.grant_id), ot.id);
        end
      end
      if (bus.cpu_mem_ready != '0) begin
        if (rdy_q.size() == 0) chk("unexpected_ready", 32'(bus.cpu_mem_ready), 0);
        else begin
          ot = rdy_q.pop_front();
          chk("ready_cycle", cyc, ot.rdy_cyc);
          chk("ready_vec", 32'(bus.cpu_mem_ready), 32'(1) << ot.id);
          chk("ready_grant_id", 32'(bus.grant_id), ot.id);
          chk("ready_mem_addr", 32'(bus.mem_addr), 32'(ot.addr));
          ack_cnt[ot.id]++;
          got_ids.push_back(ot.id);
          data_due = cyc + 1;
          data_exp = ot.data;
        end
      end
      if (cyc == data_due) begin
        chk("ack_data", 32'(bus.cpu_mem_data), 32'(data_exp));
        held = data_exp;
      end else begin
        chk("data_hold", 32'(bus.cpu_mem_data), 32'(held));
      end
      chk("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end
    prev_en  = bus.mem_en;
    prev_rst = rst;
  end

  // CPU agents: hold valid until own ready; optionally re-request at once
  int seen [N];
  task automatic drive_cycle(input int p_req, input bit keep_on);
    for (int i = 0; i < N; i++) begin
      if (ack_cnt[i] != seen[i]) begin
        seen[i] = ack_cnt[i];
        if (keep_on) bus.cpu_mem_addr[i*AW +: AW] = AW'($urandom);
        else bus.cpu_mem_valid[i] = 1'b0;
      end else if (!bus.cpu_mem_valid[i] && int'($urandom_range(99)) < p_req) begin
        bus.cpu_mem_valid[i] = 1'b1;
        bus.cpu_mem_addr[i*AW +: AW] = AW'($urandom);
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge clk); #1;
      drive_cycle(0, 1'b0);
      if (bus.cpu_mem_valid == '0 && !bus.busy && rdy_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_mem_en();
    bit seen_en;
    seen_en = 1'b0;
    for (int n = 0; n < 30 && !seen_en; n++) begin
      @(posedge clk); #3;
      if (bus.mem_en) seen_en = 1'b1;
    end
    if (!seen_en) chk("mem_en_timeout", 0, 1);
  endtask

  int fair_exp [6] = '{0, 1, 2, 3, 0, 1};
  int base;
  int acks1;

  initial begin
    for (int i = 0; i < (1<<AW); i++) tbl[i] = DW'($urandom);
    for (int i = 0; i < N; i++) seen[i] = 0;
    bus.cpu_mem_valid = '0;
    bus.cpu_mem_addr  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // Fairness: all CPUs requesting continuously from reset
    bus.cpu_mem_valid = '1;
    for (int i = 0; i < N; i++) bus.cpu_mem_addr[i*AW +: AW] = AW'($urandom);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      drive_cycle(0, 1'b1);
    end
    drain();
    chk("fair_count_ok", 32'(got_ids.size() >= 6), 1);
    if (got_ids.size() >= 6)
      for (int k = 0; k < 6; k++) chk("fair_order", got_ids[k], fair_exp[k]);

    // Random traffic, sparse then dense with immediate re-requests
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      drive_cycle(25, 1'b0);
    end
    drain();
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      drive_cycle(60, 1'b1);
    end
    drain();

    // Reset one cycle after mem_en: aborted read must never be acked
    acks1 = ack_cnt[1];
    @(posedge clk); #1;
    bus.cpu_mem_valid[1] = 1'b1;
    bus.cpu_mem_addr[1*AW +: AW] = 11'h155;
    wait_mem_en();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cpu_mem_valid = '0;
    @(posedge clk); #3;
    chk("abort_ready", 32'(bus.cpu_mem_ready), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_mem_en", 32'(bus.mem_en), 0);
    chk("abort_data", 32'(bus.cpu_mem_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = got_ids.size();
    bus.cpu_mem_valid[2] = 1'b1;
    bus.cpu_mem_addr[2*AW +: AW] = 11'h2A3;
    bus.cpu_mem_valid[0] = 1'b1;
    bus.cpu_mem_addr[0*AW +: AW] = 11'h00C;
    drain();
    chk("abort_no_ack", ack_cnt[1], acks1);
    chk("post_rst_count", got_ids.size() - base, 2);
    if (got_ids.size() - base == 2) begin
      chk("post_rst_first", got_ids[base], 0);
      chk("post_rst_second", got_ids[base+1], 2);
    end

    // Late arrival during an in-flight read waits for that read to finish
    base = got_ids.size();
    @(posedge clk); #1;
    bus.cpu_mem_valid[1] = 1'b1;
    bus.cpu_mem_addr[1*AW +: AW] = 11'h7FF;
    wait_mem_en();
    @(posedge clk); #1;
    bus.cpu_mem_valid[0] = 1'b1;
    bus.cpu_mem_addr[0*AW +: AW] = 11'h0F5;
    drain();
    chk("late_count", got_ids.size() - base, 2);
    if (got_ids.size() - base == 2) begin
      chk("late_first", got_ids[base], 1);
      chk("late_second", got_ids[base+1], 0);
    end

    repeat (5) @(posedge clk);
    #3;
    chk("sb_empty_rdy", rdy_q.size(), 0);
    chk("sb_empty_en", en_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
